// File: rtl/dcache_if.sv
// dcache_if: bundles the CPU, data-cache SRAM and data-memory signals of the
// data-cache controller. The master modport is the controller view; the slave
// modport is the environment view (CPU, SRAM and memory).
interface dcache_if;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic         cpu_MemRead_i;
    logic         cpu_MemWrite_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;

    logic [3:0]   sram_addr_o;
    logic [24:0]  sram_tag_o;
    logic [255:0] sram_data_o;
    logic         sram_enable_o;
    logic         sram_write_o;
    logic [24:0]  sram_tag_i;
    logic [255:0] sram_data_i;
    logic         sram_hit_i;

    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    modport master (
        input  cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
        input  sram_tag_i, sram_data_i, sram_hit_i,
        input  mem_data_i, mem_ack_i,
        output cpu_data_o, cpu_stall_o,
        output sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
        output mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
    );

    modport slave (
        output cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
        output sram_tag_i, sram_data_i, sram_hit_i,
        output mem_data_i, mem_ack_i,
        input  cpu_data_o, cpu_stall_o,
        input  sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
        input  mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
    );
endinterface

// File: rtl/dcache_controller.sv
// dcache_controller: data-cache controller for a 2-way, 16-set cache with
// 32-byte lines. Hits are served combinationally; misses run an optional
// write-back of a dirty victim followed by a line refill from memory.
// Optional macro DCACHE_PERF_CNT_EN adds access/miss/write-back counters.
//
// state      | meaning
// IDLE       | serving hits, detecting misses
// MISS       | one cycle to inspect and latch the victim
// WRITEBACK  | dirty victim line being written to memory
// READMISS   | requested line being fetched; refill written on ack
// READMISSOK | refill visible in SRAM, returning to IDLE
module dcache_controller (
    input  logic        clk_i,
    input  logic        rst_i,
    dcache_if.master    bus
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0] access_cnt_o,
    output logic [31:0] miss_cnt_o,
    output logic [31:0] wb_cnt_o
`endif
);
    typedef enum logic [2:0] {
        IDLE,
        MISS,
        WRITEBACK,
        READMISS,
        READMISSOK
    } state_t;

    state_t       state_q, state_d;
    logic         mem_enable_q, mem_enable_d;
    logic         mem_write_q, mem_write_d;
    logic [31:0]  mem_addr_q, mem_addr_d;
    logic [255:0] victim_data_q, victim_data_d;

    logic         req;
    logic         hit;
    logic [3:0]   idx;
    logic [22:0]  cpu_tag;
    logic [2:0]   word;
    logic         write_hit;
    logic         refill;
    logic [255:0] merged_line;
    logic [1:0]   unused_addr_bits;

    assign req     = bus.cpu_MemRead_i | bus.cpu_MemWrite_i;
    assign hit     = bus.sram_hit_i;
    assign idx     = bus.cpu_addr_i[8:5];
    assign cpu_tag = bus.cpu_addr_i[31:9];
    assign word    = bus.cpu_addr_i[4:2];
    assign unused_addr_bits = bus.cpu_addr_i[1:0];

    // Reset suppresses SRAM writes so an aborted miss never corrupts a line.
    assign write_hit = (state_q == IDLE) && bus.cpu_MemWrite_i && hit && !rst_i;
    assign refill    = (state_q == READMISS) && bus.mem_ack_i && !rst_i;

    // Store data merged into the hit line at the addressed word.
    always_comb begin
        merged_line = bus.sram_data_i;
        merged_line[{word, 5'b0} +: 32] = bus.cpu_data_i;
    end

    assign bus.cpu_stall_o   = req & ~hit;
    assign bus.cpu_data_o    = req ? bus.sram_data_i[{word, 5'b0} +: 32] : 32'h0;
    assign bus.sram_addr_o   = idx;
    assign bus.sram_enable_o = req;
    assign bus.sram_write_o  = write_hit | refill;
    // Tag bit 23 set tells the SRAM this is a write-hit, clear means refill.
    assign bus.sram_tag_o    = write_hit ? {2'b11, cpu_tag} : {2'b10, cpu_tag};
    assign bus.sram_data_o   = write_hit ? merged_line : bus.mem_data_i;

    assign bus.mem_enable_o  = mem_enable_q;
    assign bus.mem_write_o   = mem_write_q;
    assign bus.mem_addr_o    = mem_addr_q;
    assign bus.mem_data_o    = victim_data_q;

    // Next-state and registered memory-request outputs.
    always_comb begin
        state_d       = state_q;
        mem_enable_d  = mem_enable_q;
        mem_write_d   = mem_write_q;
        mem_addr_d    = mem_addr_q;
        victim_data_d = victim_data_q;
        case (state_q)
            IDLE: begin
                if (req && !hit) begin
                    state_d = MISS;
                end
            end
            MISS: begin
                victim_data_d = bus.sram_data_i;
                mem_enable_d  = 1'b1;
                if (bus.sram_tag_i[24] && bus.sram_tag_i[23]) begin
                    state_d     = WRITEBACK;
                    mem_write_d = 1'b1;
                    mem_addr_d  = {bus.sram_tag_i[22:0], idx, 5'b0};
                end else begin
                    state_d     = READMISS;
                    mem_write_d = 1'b0;
                    mem_addr_d  = {cpu_tag, idx, 5'b0};
                end
            end
            WRITEBACK: begin
                if (bus.mem_ack_i) begin
                    state_d     = READMISS;
                    mem_write_d = 1'b0;
                    mem_addr_d  = {cpu_tag, idx, 5'b0};
                end
            end
            READMISS: begin
                if (bus.mem_ack_i) begin
                    state_d      = READMISSOK;
                    mem_enable_d = 1'b0;
                end
            end
            READMISSOK: begin
                state_d = IDLE;
            end
            default: begin
                state_d      = IDLE;
                mem_enable_d = 1'b0;
                mem_write_d  = 1'b0;
            end
        endcase
    end

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] access_cnt_q, access_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;
    logic [31:0] wb_cnt_q, wb_cnt_d;

    // Event counters; wrap naturally at 2^32.
    always_comb begin
        access_cnt_d = access_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        wb_cnt_d     = wb_cnt_q;
        if (req && hit) begin
            access_cnt_d = access_cnt_q + 32'd1;
        end
        if (state_q == IDLE && req && !hit) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
        if (state_q == WRITEBACK && bus.mem_ack_i) begin
            wb_cnt_d = wb_cnt_q + 32'd1;
        end
    end

    assign access_cnt_o = access_cnt_q;
    assign miss_cnt_o   = miss_cnt_q;
    assign wb_cnt_o     = wb_cnt_q;
`endif

    // All controller state, synchronously reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            mem_enable_q  <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_addr_q    <= 32'h0;
            victim_data_q <= 256'h0;
`ifdef DCACHE_PERF_CNT_EN
            access_cnt_q  <= 32'h0;
            miss_cnt_q    <= 32'h0;
            wb_cnt_q      <= 32'h0;
`endif
        end else begin
            state_q       <= state_d;
            mem_enable_q  <= mem_enable_d;
            mem_write_q   <= mem_write_d;
            mem_addr_q    <= mem_addr_d;
            victim_data_q <= victim_data_d;
`ifdef DCACHE_PERF_CNT_EN
            access_cnt_q  <= access_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
            wb_cnt_q      <= wb_cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed bench for the data-cache controller with a
// behavioural 2-way SRAM (LRU replacement) and a fixed-latency memory.
module tb_dcache_controller;
    localparam int MEM_LAT = 10;

    logic clk = 1'b0;
    logic rst;
    logic sram_clr;
    logic ack_force;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    dcache_if bus ();

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] access_cnt, miss_cnt, wb_cnt;
`endif

    dcache_controller dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
`ifdef DCACHE_PERF_CNT_EN
        ,
        .access_cnt_o (access_cnt),
        .miss_cnt_o   (miss_cnt),
        .wb_cnt_o     (wb_cnt)
`endif
    );

    function automatic logic [255:0] line_of(input logic [31:0] a);
        logic [255:0] r;
        for (int w = 0; w < 8; w++) r[w*32 +: 32] = a + w + 32'hA500_0000;
        return r;
    endfunction

    // SRAM model: 2 ways x 16 sets, one LRU bit per set.
    logic         v_a [2][16];
    logic         d_a [2][16];
    logic [22:0]  t_a [2][16];
    logic [255:0] dat_a [2][16];
    logic         lru [16];
    logic         hit0, hit1, way_sel;
    logic [3:0]   sidx;
    int           sram_wr_cnt;
    logic [24:0]  last_wr_tag;

    always_comb begin
        sidx = bus.sram_addr_o;
        hit0 = v_a[0][sidx] && (t_a[0][sidx] == bus.cpu_addr_i[31:9]);
        hit1 = v_a[1][sidx] && (t_a[1][sidx] == bus.cpu_addr_i[31:9]);
        way_sel = hit0 ? 1'b0 : (hit1 ? 1'b1 : lru[sidx]);
        bus.sram_hit_i  = hit0 | hit1;
        bus.sram_tag_i  = {v_a[way_sel][sidx], d_a[way_sel][sidx], t_a[way_sel][sidx]};
        bus.sram_data_i = dat_a[way_sel][sidx];
    end

    always @(posedge clk) begin
        if (sram_clr) begin
            for (int s = 0; s < 16; s++) begin
                v_a[0][s] <= 1'b0; v_a[1][s] <= 1'b0;
                d_a[0][s] <= 1'b0; d_a[1][s] <= 1'b0;
                t_a[0][s] <= '0;   t_a[1][s] <= '0;
                dat_a[0][s] <= '0; dat_a[1][s] <= '0;
                lru[s] <= 1'b0;
            end
            sram_wr_cnt <= 0;
            last_wr_tag <= '0;
        end else if (bus.sram_enable_o) begin
            if (bus.sram_write_o) begin
                v_a[way_sel][sidx]   <= bus.sram_tag_o[24];
                d_a[way_sel][sidx]   <= bus.sram_tag_o[23];
                t_a[way_sel][sidx]   <= bus.sram_tag_o[22:0];
                dat_a[way_sel][sidx] <= bus.sram_data_o;
                sram_wr_cnt <= sram_wr_cnt + 1;
                last_wr_tag <= bus.sram_tag_o;
            end
            if (bus.sram_write_o || bus.sram_hit_i) lru[sidx] <= ~way_sel;
        end
    end

    // Memory model: ack on the MEM_LAT-th cycle of a request.
    int   lat_cnt;
    logic ack_q;
    assign bus.mem_ack_i = ack_q | ack_force;

    always @(posedge clk) begin
        if (rst) begin
            lat_cnt <= 0;
            ack_q   <= 1'b0;
        end else if (bus.mem_enable_o && !ack_q) begin
            if (lat_cnt == MEM_LAT - 2) begin
                ack_q          <= 1'b1;
                lat_cnt        <= 0;
                bus.mem_data_i <= line_of(bus.mem_addr_o);
            end else begin
                lat_cnt <= lat_cnt + 1;
                ack_q   <= 1'b0;
            end
        end else begin
            lat_cnt <= 0;
            ack_q   <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        bus.cpu_MemRead_i  = rd;
        bus.cpu_MemWrite_i = wr;
        bus.cpu_addr_i     = a;
        bus.cpu_data_i     = d;
    endtask

    task automatic run_miss(output int cyc, output logic wb_seen, output logic [31:0] wb_a,
                            output logic [255:0] wb_d, output logic [31:0] fetch_a);
        cyc = 0; wb_seen = 1'b0; wb_a = '0; wb_d = '0; fetch_a = 32'hFFFF_FFFF;
        while (bus.cpu_stall_o && cyc < 100) begin
            tick();
            cyc++;
            if (bus.mem_enable_o && bus.mem_write_o && !wb_seen) begin
                wb_seen = 1'b1; wb_a = bus.mem_addr_o; wb_d = bus.mem_data_o;
            end
            if (bus.mem_enable_o && !bus.mem_write_o) fetch_a = bus.mem_addr_o;
        end
        checks++;
        if (cyc >= 100) begin
            failures++;
            $display("FAIL miss_timeout stall still high after %0d cycles", cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; sram_clr = 1'b1; ack_force = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) tick();
        sram_clr = 1'b0;
        checks++; if (bus.mem_enable_o !== 1'b0) begin failures++; $display("FAIL rst_mem_enable got %b exp 0", bus.mem_enable_o); end
        checks++; if (bus.mem_write_o !== 1'b0) begin failures++; $display("FAIL rst_mem_write got %b exp 0", bus.mem_write_o); end
        checks++; if (bus.mem_addr_o !== 32'h0) begin failures++; $display("FAIL rst_mem_addr got %h exp 0", bus.mem_addr_o); end
        checks++; if (bus.mem_data_o !== 256'h0) begin failures++; $display("FAIL rst_mem_data got nonzero exp 0"); end
        checks++; if (bus.sram_write_o !== 1'b0) begin failures++; $display("FAIL rst_sram_write got %b exp 0", bus.sram_write_o); end
        checks++; if (bus.cpu_stall_o !== 1'b0 || bus.cpu_data_o !== 32'h0) begin
            failures++; $display("FAIL rst_cpu stall %b data %h exp 0 0", bus.cpu_stall_o, bus.cpu_data_o);
        end
`ifdef DCACHE_PERF_CNT_EN
        checks++; if ({access_cnt, miss_cnt, wb_cnt} !== 96'h0) begin failures++; $display("FAIL rst_counters got %h %h %h exp 0", access_cnt, miss_cnt, wb_cnt); end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_clean_miss();
        int cyc; logic wb_seen; logic [31:0] wb_a, fetch_a; logic [255:0] wb_d;
        int wr0;
        wr0 = sram_wr_cnt;
        drive(1'b1, 1'b0, 32'h0000_0004, 32'h0);
        #1;
        checks++; if (bus.cpu_stall_o !== 1'b1) begin failures++; $display("FAIL cold_stall got %b exp 1", bus.cpu_stall_o); end
        run_miss(cyc, wb_seen, wb_a, wb_d, fetch_a);
        checks++; if (cyc != 12) begin failures++; $display("FAIL clean_latency got %0d exp 12", cyc); end
        checks++; if (fetch_a !== 32'h0) begin failures++; $display("FAIL clean_fetch_addr got %h exp 0", fetch_a); end
        checks++; if (wb_seen !== 1'b0) begin failures++; $display("FAIL clean_no_wb got %b exp 0", wb_seen); end
        checks++; if (last_wr_tag !== {2'b10, 23'h0} || sram_wr_cnt != wr0 + 1) begin
            failures++; $display("FAIL refill_tag got %h writes %0d exp %h writes %0d", last_wr_tag, sram_wr_cnt - wr0, {2'b10, 23'h0}, 1);
        end
        checks++; if (bus.cpu_data_o !== 32'hA500_0001) begin failures++; $display("FAIL clean_load_data got %h exp A5000001", bus.cpu_data_o); end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_write_hit();
        logic [255:0] exp;
        exp = line_of(32'h0);
        exp[64 +: 32] = 32'hDEAD_BEEF;
        drive(1'b0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF);
        #1;
        checks++; if (bus.cpu_stall_o !== 1'b0) begin failures++; $display("FAIL wh_stall got %b exp 0", bus.cpu_stall_o); end
        checks++; if (bus.sram_write_o !== 1'b1) begin failures++; $display("FAIL wh_write got %b exp 1", bus.sram_write_o); end
        checks++; if (bus.sram_tag_o !== {2'b11, 23'h0}) begin failures++; $display("FAIL wh_tag got %h exp %h", bus.sram_tag_o, {2'b11, 23'h0}); end
        checks++; if (bus.sram_data_o !== exp) begin failures++; $display("FAIL wh_data got %h exp %h", bus.sram_data_o, exp); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_dirty_writeback();
        int cyc; logic wb_seen; logic [31:0] wb_a, fetch_a; logic [255:0] wb_d, exp;
        drive(1'b0, 1'b1, 32'h0000_0200, 32'h1234_5678);
        #1;
        run_miss(cyc, wb_seen, wb_a, wb_d, fetch_a);
        checks++; if (cyc != 12 || wb_seen !== 1'b0) begin failures++; $display("FAIL store_miss cycles %0d wb %b exp 12 0", cyc, wb_seen); end
        tick();
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        exp = line_of(32'h0);
        exp[64 +: 32] = 32'hDEAD_BEEF;
        drive(1'b1, 1'b0, 32'h0000_0400, 32'h0);
        #1;
        run_miss(cyc, wb_seen, wb_a, wb_d, fetch_a);
        checks++; if (cyc != 22) begin failures++; $display("FAIL dirty_latency got %0d exp 22", cyc); end
        checks++; if (wb_seen !== 1'b1 || wb_a !== 32'h0) begin failures++; $display("FAIL wb_addr seen %b got %h exp 0", wb_seen, wb_a); end
        checks++; if (wb_d !== exp) begin failures++; $display("FAIL wb_data got %h exp %h", wb_d, exp); end
        checks++; if (fetch_a !== 32'h0000_0400) begin failures++; $display("FAIL dirty_fetch_addr got %h exp 400", fetch_a); end
`ifdef DCACHE_PERF_CNT_EN
        checks++; if (wb_cnt !== 32'd1 || miss_cnt !== 32'd3) begin failures++; $display("FAIL perf_wb_miss got %0d %0d exp 1 3", wb_cnt, miss_cnt); end
`endif
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_read_write_same();
        logic [255:0] exp;
        exp = line_of(32'h0000_0400);
        exp[64 +: 32] = 32'hCAFE_F00D;
        drive(1'b1, 1'b1, 32'h0000_0408, 32'hCAFE_F00D);
        #1;
        checks++; if (bus.cpu_stall_o !== 1'b0 || bus.sram_write_o !== 1'b1) begin
            failures++; $display("FAIL rw_store stall %b write %b exp 0 1", bus.cpu_stall_o, bus.sram_write_o);
        end
        checks++; if (bus.sram_tag_o !== {2'b11, 23'h2}) begin failures++; $display("FAIL rw_tag got %h exp %h", bus.sram_tag_o, {2'b11, 23'h2}); end
        checks++; if (bus.sram_data_o !== exp) begin failures++; $display("FAIL rw_data got %h exp %h", bus.sram_data_o, exp); end
        tick();
        drive(1'b1, 1'b0, 32'h0000_0408, 32'h0);
        #1;
        checks++; if (bus.cpu_data_o !== 32'hCAFE_F00D) begin failures++; $display("FAIL rw_readback got %h exp CAFEF00D", bus.cpu_data_o); end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_reset_mid_miss();
        int cyc; logic wb_seen; logic [31:0] wb_a, fetch_a; logic [255:0] wb_d;
        int wr0;
        drive(1'b1, 1'b0, 32'h0000_0020, 32'h0);
        #1;
        tick();
        tick();
        checks++; if (bus.mem_enable_o !== 1'b1 || bus.mem_write_o !== 1'b0 || bus.mem_addr_o !== 32'h20) begin
            failures++; $display("FAIL rm_fetch en %b wr %b addr %h exp 1 0 20", bus.mem_enable_o, bus.mem_write_o, bus.mem_addr_o);
        end
        wr0 = sram_wr_cnt;
        rst = 1'b1;
        tick();
        checks++; if (bus.mem_enable_o !== 1'b0) begin failures++; $display("FAIL rst_abort_enable got %b exp 0", bus.mem_enable_o); end
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        checks++; if (bus.mem_enable_o !== 1'b0 || sram_wr_cnt != wr0) begin
            failures++; $display("FAIL rst_abort_quiet en %b writes %0d exp 0 0", bus.mem_enable_o, sram_wr_cnt - wr0);
        end
        drive(1'b1, 1'b0, 32'h0000_0020, 32'h0);
        #1;
        run_miss(cyc, wb_seen, wb_a, wb_d, fetch_a);
        checks++; if (cyc != 12 || fetch_a !== 32'h20) begin failures++; $display("FAIL post_rst_miss cycles %0d addr %h exp 12 20", cyc, fetch_a); end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_spurious_ack();
`ifdef DCACHE_PERF_CNT_EN
        logic [95:0] snap;
        snap = {access_cnt, miss_cnt, wb_cnt};
`endif
        ack_force = 1'b1;
        #1;
        checks++; if (bus.sram_write_o !== 1'b0) begin failures++; $display("FAIL spur_sram_write got %b exp 0", bus.sram_write_o); end
        tick();
        ack_force = 1'b0;
        tick();
        checks++; if (bus.mem_enable_o !== 1'b0) begin failures++; $display("FAIL spur_mem_enable got %b exp 0", bus.mem_enable_o); end
`ifdef DCACHE_PERF_CNT_EN
        checks++; if ({access_cnt, miss_cnt, wb_cnt} !== snap) begin failures++; $display("FAIL spur_counters got %h exp %h", {access_cnt, miss_cnt, wb_cnt}, snap); end
`endif
        drive(1'b1, 1'b0, 32'h0000_0404, 32'h0);
        #1;
        checks++; if (bus.cpu_stall_o !== 1'b0 || bus.cpu_data_o !== 32'hA500_0401) begin
            failures++; $display("FAIL spur_then_hit stall %b data %h exp 0 A5000401", bus.cpu_stall_o, bus.cpu_data_o);
        end
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
    endtask

    initial begin
        test_reset();
        test_clean_miss();
        test_write_hit();
        test_dirty_writeback();
        test_read_write_same();
        test_reset_mid_miss();
        test_spurious_ack();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
